lif_array_scheduler: RTL

//  Time-multiplexes one leaky integrate-and-fire update datapath across N_NEURONS neurons.
//  On each accepted tick it sweeps all neurons in index order, 2 cycles per neuron:

---
 rtl/lif_array_scheduler_if.sv | 30 +++
 rtl/lif_array_scheduler.sv | 114 +++++++++++
 2 files changed

// File: rtl/lif_array_scheduler_if.sv
// Tick/threshold control, current-fetch bus, spike output and debug read port of the LIF array scheduler.
// master = surrounding logic (tick source, current source, spike consumer); slave = the scheduler.
interface lif_array_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = $clog2(N_NEURONS)
);
  logic                 en;
  logic                 tick;
  logic [7:0]           threshold;
  logic                 clr_ovr;
  logic                 cur_req;
  logic [IDX_W-1:0]     cur_idx;
  logic [7:0]           cur_data;
  logic                 busy;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 spike_valid;
  logic                 overrun;
  logic [IDX_W-1:0]     dbg_idx;
  logic [7:0]           dbg_mem;

  modport master (
    output en, tick, threshold, clr_ovr, cur_data, dbg_idx,
    input  cur_req, cur_idx, busy, spike_vec, spike_valid, overrun, dbg_mem
  );

  modport slave (
    input  en, tick, threshold, clr_ovr, cur_data, dbg_idx,
    output cur_req, cur_idx, busy, spike_vec, spike_valid, overrun, dbg_mem
  );
endinterface

// File: rtl/lif_array_scheduler.sv
// One shared leaky integrate-and-fire datapath swept over N_NEURONS neurons, 2 cycles per neuron;
// tick to spike_valid is 2N+1 cycles, and ticks arriving mid-sweep are dropped and flagged in overrun.
module lif_array_scheduler #(
  parameter int N_NEURONS    = 4,
  parameter int LEAK_SHIFT   = 2,
  parameter int REFRAC_TICKS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  lif_array_scheduler_if.slave  bus
);
  localparam int IDX_W = $clog2(N_NEURONS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           thr_q;
  logic [7:0]           cur_q;
  logic [N_NEURONS-1:0] shadow;
  logic [N_NEURONS-1:0] spike_vec_q;
  logic                 overrun_q;
  logic [7:0]           mem    [N_NEURONS];
  logic [2:0]           refrac [N_NEURONS];

  logic [7:0]           s_cur;
  logic [2:0]           r_cur;
  logic [7:0]           leaked;
  logic [8:0]           sum;
  logic [7:0]           v;
  logic                 fire;
  logic [N_NEURONS-1:0] fire_mask;

  // leaked = s - s>>k can never underflow, so only the add needs a carry bit
  always_comb begin
    s_cur     = mem[idx];
    r_cur     = refrac[idx];
    leaked    = s_cur - (s_cur >> LEAK_SHIFT);
    sum       = {1'b0, leaked} + {1'b0, cur_q};
    v         = sum[8] ? 8'hFF : sum[7:0];
    fire      = (r_cur == 3'd0) && (v >= thr_q);
    fire_mask = fire ? (N_NEURONS'(1) << idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      thr_q       <= '0;
      cur_q       <= '0;
      shadow      <= '0;
      spike_vec_q <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem[i]    <= '0;
        refrac[i] <= '0;
      end
    end else begin
      // a dropped tick outranks a simultaneous clear
      if (bus.tick && (state != S_IDLE))
        overrun_q <= 1'b1;
      else if (bus.clr_ovr)
        overrun_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.tick && bus.en) begin
            thr_q  <= bus.threshold;
            idx    <= '0;
            shadow <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          cur_q <= bus.cur_data;
          state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (r_cur != 3'd0) begin
            mem[idx]    <= '0;
            refrac[idx] <= r_cur - 3'd1;
          end else if (fire) begin
            mem[idx]    <= '0;
            refrac[idx] <= 3'(REFRAC_TICKS);
          end else begin
            mem[idx]    <= v;
          end
          // publish on entry to DONE so spike_vec is already new while spike_valid is high
          if (idx == IDX_W'(N_NEURONS - 1)) begin
            spike_vec_q <= shadow | fire_mask;
            state       <= S_DONE;
          end else begin
            shadow <= shadow | fire_mask;
            idx    <= idx + IDX_W'(1);
            state  <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // idx only moves on entry to FETCH, so it already holds its last value elsewhere
  assign bus.cur_req     = (state == S_FETCH);
  assign bus.cur_idx     = idx;
  assign bus.busy        = (state != S_IDLE);
  assign bus.spike_vec   = spike_vec_q;
  assign bus.spike_valid = (state == S_DONE);
  assign bus.overrun     = overrun_q;
  assign bus.dbg_mem     = mem[bus.dbg_idx];
endmodule
